// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared constants for the multiply/divide sequencer:
//   - 3-bit state encoding, plus the enum built on it
//   - operation kind constants (KIND_MULT / KIND_DIV)
//   - HI/LO source mux select constants (SEL_MULT / SEL_DIV)
//   - watchdog counter width
// ---------------------------------------------------------------------------
package muldiv_pkg;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_COMMIT = 3'd3;
   localparam logic [2:0] S_EXC    = 3'd4;
   localparam logic [2:0] S_ABORT  = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE   = S_IDLE,
      ST_START  = S_START,
      ST_WAIT   = S_WAIT,
      ST_COMMIT = S_COMMIT,
      ST_EXC    = S_EXC,
      ST_ABORT  = S_ABORT
   } state_t;

   localparam logic KIND_MULT = 1'b0;
   localparam logic KIND_DIV  = 1'b1;

   localparam logic SEL_MULT  = 1'b0;
   localparam logic SEL_DIV   = 1'b1;

   localparam int WDOG_W = 8;

   // Maps the latched operation kind onto the HI/LO mux select value.
   function automatic logic kind_to_sel(input logic kind);
      return (kind == KIND_DIV) ? SEL_DIV : SEL_MULT;
   endfunction

endpackage

// File: rtl/muldiv_watchdog.sv
// ---------------------------------------------------------------------------
// muldiv_watchdog
// 8-bit cycle counter guarding the WAIT state of the sequencer.
// Ports:
//   clk     in  system clock
//   reset   in  asynchronous, active-high
//   i_clr   in  synchronous clear to zero (has priority over i_en)
//   i_en    in  count enable, +1 per cycle
//   o_tc    out terminal count: counter == TIMEOUT_CYCLES-1
// The sequencer leaves WAIT on terminal count, so the counter never wraps.
// ---------------------------------------------------------------------------
module muldiv_watchdog
   import muldiv_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam logic [WDOG_W-1:0] TC_VALUE = WDOG_W'(TIMEOUT_CYCLES - 1);

   logic [WDOG_W-1:0] r_count;

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_tc = (r_count == TC_VALUE);

endmodule

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
// Sequences one MULT or DIV operation on the shared multiply/divide resource:
// pulses the selected unit's init, waits for its end handshake, then commits
// HI and LO together, or reports divide-by-zero / watchdog timeout.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   op_valid, op_is_div   request from the control unit (sampled in IDLE)
//   op_ready              idle and accepting
//   busy                  operation outstanding (START/WAIT/COMMIT)
//   mult_init, mult_end   multiplier start pulse / done
//   div_init, div_end     divider start pulse / done
//   div_zero              divider divide-by-zero flag
//   sel_lo, sel_hi        HI/LO source mux selects (0 = mult, 1 = div)
//   lo_w, hi_w            HI/LO register write enables
//   done                  one-cycle pulse, result committed
//   div_exc               one-cycle pulse, divide-by-zero, no writes
//   timeout               one-cycle pulse, watchdog abort, no writes
//   rd_req, rd_stall      MFHI/MFLO decode in / stall out
// Outputs are registered and loaded with the values of the state being
// entered, so they behave as Moore outputs of the state register.
// ---------------------------------------------------------------------------
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic op_valid,
   input  logic op_is_div,
   output logic op_ready,
   output logic busy,
   output logic mult_init,
   input  logic mult_end,
   output logic div_init,
   input  logic div_end,
   input  logic div_zero,
   output logic sel_lo,
   output logic sel_hi,
   output logic lo_w,
   output logic hi_w,
   output logic done,
   output logic div_exc,
   output logic timeout,
   input  logic rd_req,
   output logic rd_stall
);

   state_t r_state;
   logic   r_kind;
   logic   r_op_ready;
   logic   r_busy;
   logic   r_mult_init;
   logic   r_div_init;
   logic   r_commit;
   logic   r_div_exc;
   logic   r_timeout;

   logic   w_sel_end;
   logic   w_zero;
   logic   w_tc;
   logic   w_wd_clr;
   logic   w_wd_en;

   // Only the selected unit's handshake matters; the idle unit's lines may
   // carry stale or stray values.
   assign w_sel_end = (r_kind == KIND_DIV) ? div_end : mult_end;
   assign w_zero    = (r_kind == KIND_DIV) && div_zero;

   assign w_wd_clr  = (r_state == ST_START);
   assign w_wd_en   = (r_state == ST_WAIT);

   muldiv_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk   (clk),
      .reset (reset),
      .i_clr (w_wd_clr),
      .i_en  (w_wd_en),
      .o_tc  (w_tc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_kind      <= KIND_MULT;
         r_op_ready  <= 1'b1;
         r_busy      <= 1'b0;
         r_mult_init <= 1'b0;
         r_div_init  <= 1'b0;
         r_commit    <= 1'b0;
         r_div_exc   <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         // Pulse outputs default low; only the transition into their state
         // raises them, which makes each pulse exactly one cycle long.
         r_mult_init <= 1'b0;
         r_div_init  <= 1'b0;
         r_commit    <= 1'b0;
         r_div_exc   <= 1'b0;
         r_timeout   <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (op_valid) begin
                  r_state     <= ST_START;
                  r_kind      <= op_is_div;
                  r_op_ready  <= 1'b0;
                  r_busy      <= 1'b1;
                  r_mult_init <= (op_is_div == KIND_MULT);
                  r_div_init  <= (op_is_div == KIND_DIV);
               end
            end

            ST_START: begin
               r_state <= ST_WAIT;
            end

            ST_WAIT: begin
               if (w_zero) begin
                  r_state   <= ST_EXC;
                  r_busy    <= 1'b0;
                  r_div_exc <= 1'b1;
               end else if (w_sel_end) begin
                  r_state  <= ST_COMMIT;
                  r_commit <= 1'b1;
               end else if (w_tc) begin
                  r_state   <= ST_ABORT;
                  r_busy    <= 1'b0;
                  r_timeout <= 1'b1;
               end
            end

            ST_COMMIT, ST_EXC, ST_ABORT: begin
               r_state    <= ST_IDLE;
               r_op_ready <= 1'b1;
               r_busy     <= 1'b0;
            end

            default: begin
               r_state    <= ST_IDLE;
               r_op_ready <= 1'b1;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign op_ready  = r_op_ready;
   assign busy      = r_busy;
   assign mult_init = r_mult_init;
   assign div_init  = r_div_init;
   assign sel_lo    = kind_to_sel(r_kind);
   assign sel_hi    = kind_to_sel(r_kind);
   assign lo_w      = r_commit;
   assign hi_w      = r_commit;
   assign done      = r_commit;
   assign div_exc   = r_div_exc;
   assign timeout   = r_timeout;
   assign rd_stall  = rd_req & r_busy;

endmodule
